// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker state type, default geometry and the
// next-state function also used by the LFSR generator.
package lfsr_pkg;

    localparam int unsigned LFSR_MAX_W = 32;
    localparam int unsigned LFSR_DEF_W = 4;
    localparam logic [LFSR_DEF_W-1:0] LFSR_DEF_TAPS = 4'b1100;
    localparam int unsigned RUN_W = 4;

    typedef enum logic {
        ST_HUNT,
        ST_LOCKED
    } lfsr_chk_state_t;

    // Callers zero-extend cur/taps to LFSR_MAX_W and keep the low WIDTH bits.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] cur,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return {cur[LFSR_MAX_W-2:0], ^(cur & taps)};
    endfunction

endpackage

// File: rtl/lfsr_chk_run.sv
// Saturating run counter with synchronous clear; o_hit flags that the next
// increment reaches the terminal count i_tc.
module lfsr_chk_run
    import lfsr_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    input  logic [RUN_W-1:0] i_tc,
    output logic             o_hit
);

    logic [RUN_W-1:0] r_cnt;

    assign o_hit = (r_cnt + RUN_W'(1)) == i_tc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + RUN_W'(1);
        end
    end

endmodule

// File: rtl/lfsr_chk.sv
// Self-synchronising LFSR sequence checker with lock detection and error count.
// Define LFSR_CHK_SAT_EN to make the error counter saturate instead of wrap.
module lfsr_chk
    import lfsr_pkg::*;
#(
    parameter int unsigned     WIDTH    = LFSR_DEF_W,
    parameter logic [WIDTH-1:0] TAPS    = LFSR_DEF_TAPS,
    parameter int unsigned     LOCK_CNT = 4,
    parameter int unsigned     LOSS_CNT = 3,
    parameter int unsigned     ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lfsr_valid_i,
    input  logic [WIDTH-1:0] lfsr_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    localparam logic [RUN_W-1:0] LOCK_TC = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] LOSS_TC = RUN_W'(LOSS_CNT);

    lfsr_chk_state_t  r_state, w_state_n;
    logic [WIDTH-1:0] r_pred, w_pred_n;
    logic             r_have_prev, w_have_prev_n;
    logic             r_err, w_err_n;
    logic [ERR_W-1:0] r_err_cnt, w_err_cnt_n, w_err_cnt_inc;

    logic [WIDTH-1:0] w_nxt_in, w_nxt_pred;
    logic             w_hunt_match;
    logic             w_run_inc, w_run_clr, w_run_hit;
    logic [RUN_W-1:0] w_run_tc;

    assign w_nxt_in   = WIDTH'(lfsr_next(LFSR_MAX_W'(lfsr_i), LFSR_MAX_W'(TAPS)));
    assign w_nxt_pred = WIDTH'(lfsr_next(LFSR_MAX_W'(r_pred), LFSR_MAX_W'(TAPS)));

    // All-zero input is excluded so a stuck-at-zero stream can never lock.
    assign w_hunt_match = r_have_prev && (lfsr_i == r_pred) && (lfsr_i != '0);

    assign w_run_tc = (r_state == ST_LOCKED) ? LOSS_TC : LOCK_TC;

`ifdef LFSR_CHK_SAT_EN
    assign w_err_cnt_inc = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + ERR_W'(1);
`else
    assign w_err_cnt_inc = r_err_cnt + ERR_W'(1);
`endif

    lfsr_chk_run u_run (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_run_inc),
        .i_clr (w_run_clr),
        .i_tc  (w_run_tc),
        .o_hit (w_run_hit)
    );

    always_comb begin
        w_state_n     = r_state;
        w_pred_n      = r_pred;
        w_have_prev_n = r_have_prev;
        w_err_n       = 1'b0;
        w_err_cnt_n   = r_err_cnt;
        w_run_inc     = 1'b0;
        w_run_clr     = 1'b0;
        if (lfsr_valid_i) begin
            case (r_state)
                ST_HUNT: begin
                    w_pred_n      = w_nxt_in;
                    w_have_prev_n = 1'b1;
                    if (w_hunt_match) begin
                        if (w_run_hit) begin
                            w_state_n = ST_LOCKED;
                            w_run_clr = 1'b1;
                        end else begin
                            w_run_inc = 1'b1;
                        end
                    end else begin
                        w_run_clr = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    // Free-running prediction: a single bad sample costs one error only.
                    w_pred_n = w_nxt_pred;
                    if (lfsr_i != r_pred) begin
                        w_err_n     = 1'b1;
                        w_err_cnt_n = w_err_cnt_inc;
                        if (w_run_hit) begin
                            w_state_n     = ST_HUNT;
                            w_pred_n      = w_nxt_in;
                            w_have_prev_n = 1'b1;
                            w_run_clr     = 1'b1;
                        end else begin
                            w_run_inc = 1'b1;
                        end
                    end else begin
                        w_run_clr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_HUNT;
            r_pred      <= '0;
            r_have_prev <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_n;
            r_pred      <= w_pred_n;
            r_have_prev <= w_have_prev_n;
            r_err       <= w_err_n;
            r_err_cnt   <= w_err_cnt_n;
        end
    end

    assign locked_o  = (r_state == ST_LOCKED);
    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_lfsr_chk.sv
// Self-checking bench for lfsr_chk: default instance plus an ERR_W=2 instance
// sharing the same stimulus, compared against a behavioural stream model.
module tb_lfsr_chk;

`ifdef LFSR_CHK_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] din = 4'd0;
    logic       locked_a, err_a, locked_b, err_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [13:0] act;

    int n_cmp = 0;
    int n_bad = 0;

    bit m_locked, m_havep, m_err;
    int m_pred, m_run, m_errs;
    int g;

    always #5 clk = ~clk;

    lfsr_chk u_dut (
        .clk(clk), .reset(rst_n), .lfsr_valid_i(valid), .lfsr_i(din),
        .locked_o(locked_a), .err_o(err_a), .err_cnt_o(cnt_a)
    );

    lfsr_chk #(.ERR_W(2)) u_dut_e2 (
        .clk(clk), .reset(rst_n), .lfsr_valid_i(valid), .lfsr_i(din),
        .locked_o(locked_b), .err_o(err_b), .err_cnt_o(cnt_b)
    );

    assign act = {locked_a, err_a, cnt_a, locked_b, err_b, cnt_b};

    // x^4+x^3+1: shift left, feedback = bit3 xor bit2
    function automatic int nxt(input int x);
        return ((x << 1) & 15) | (((x >> 3) ^ (x >> 2)) & 1);
    endfunction

    function automatic int exp_cnt(input int errs, input int w);
        int top;
        top = (1 << w) - 1;
        if (SAT) return (errs > top) ? top : errs;
        return errs & top;
    endfunction

    function automatic logic [13:0] exp_vec();
        logic [7:0] c8;
        logic [1:0] c2;
        c8 = 8'(exp_cnt(m_errs, 8));
        c2 = 2'(exp_cnt(m_errs, 2));
        return {m_locked, m_err, c8, m_locked, m_err, c2};
    endfunction

    task automatic m_clear();
        m_locked = 0; m_havep = 0; m_err = 0;
        m_pred = 0; m_run = 0; m_errs = 0;
    endtask

    task automatic step(input bit v, input int d);
        valid = v;
        din   = d[3:0];
        @(posedge clk);
        if (!rst_n) begin
            m_clear();
        end else begin
            m_err = 0;
            if (v && !m_locked) begin
                if (m_havep && d == m_pred && d != 0) begin
                    m_run++;
                    if (m_run == 4) begin m_locked = 1; m_run = 0; end
                end else begin
                    m_run = 0;
                end
                m_pred  = nxt(d);
                m_havep = 1;
            end else if (v) begin
                if (d != m_pred) begin
                    m_err = 1; m_errs++; m_run++;
                    m_pred = nxt(m_pred);
                    if (m_run == 3) begin
                        m_locked = 0; m_pred = nxt(d); m_run = 0; m_havep = 1;
                    end
                end else begin
                    m_pred = nxt(m_pred);
                    m_run  = 0;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        m_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1, $urandom_range(1, 15));
            n_cmp++;
            if (act !== 14'h0) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: got %h want 0000", i, act);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            n_cmp++;
            if (act !== exp_vec() || act !== 14'h0) begin
                n_bad++;
                $display("FAIL reset_release[%0d]: got %h want %h", i, act, exp_vec());
            end
        end
    endtask

    task automatic test_lock();
        int s[5] = '{1, 2, 4, 9, 3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, s[i]);
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++;
                $display("FAIL lock_seq[%0d]: got %h want %h", i, act, exp_vec());
            end
            if (i == 3) begin
                n_cmp++;
                if (locked_a !== 1'b0) begin
                    n_bad++;
                    $display("FAIL lock_early: got locked=%b want 0", locked_a);
                end
            end
        end
        n_cmp++;
        if (locked_a !== 1'b1 || cnt_a !== 8'd0) begin
            n_bad++;
            $display("FAIL lock_final: got locked=%b cnt=%0d want locked=1 cnt=0", locked_a, cnt_a);
        end
        g = 3;
    endtask

    task automatic test_bubbles();
        int s[5] = '{1, 2, 4, 9, 3};
        bit any_err = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, s[i]);
            any_err |= err_a;
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++;
                $display("FAIL bubble_seq[%0d]: got %h want %h", i, act, exp_vec());
            end
            if (i < 4) begin
                for (int b = 0; b < 2; b++) begin
                    step(0, $urandom_range(0, 15));
                    any_err |= err_a;
                    n_cmp++;
                    if (act !== exp_vec() || locked_a !== 1'b0) begin
                        n_bad++;
                        $display("FAIL bubble_gap[%0d.%0d]: got %h want %h", i, b, act, exp_vec());
                    end
                end
            end
        end
        n_cmp++;
        if (locked_a !== 1'b1 || any_err) begin
            n_bad++;
            $display("FAIL bubble_final: got locked=%b err_seen=%b want locked=1 err_seen=0", locked_a, any_err);
        end
        g = 3;
    endtask

    task automatic test_single_error();
        int errs0;
        errs0 = m_errs;
        for (int i = 0; i < 4; i++) begin
            g = nxt(g);
            step(1, (i == 0) ? 15 : g);
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++;
                $display("FAIL single_err[%0d]: got %h want %h", i, act, exp_vec());
            end
            if (i == 0) begin
                n_cmp++;
                if (err_a !== 1'b1) begin
                    n_bad++;
                    $display("FAIL single_err_pulse: got err=%b want 1", err_a);
                end
            end
        end
        n_cmp++;
        if (locked_a !== 1'b1 || cnt_a !== 8'(errs0 + 1) || err_a !== 1'b0) begin
            n_bad++;
            $display("FAIL single_err_final: got locked=%b cnt=%0d err=%b want 1 %0d 0",
                     locked_a, cnt_a, err_a, errs0 + 1);
        end
    endtask

    task automatic test_loss();
        int errs0;
        errs0 = m_errs;
        for (int i = 0; i < 3; i++) begin
            g = nxt(g);
            step(1, g ^ $urandom_range(1, 15));
            n_cmp++;
            if (act !== exp_vec() || err_a !== 1'b1) begin
                n_bad++;
                $display("FAIL loss_miss[%0d]: got %h want %h", i, act, exp_vec());
            end
        end
        n_cmp++;
        if (locked_a !== 1'b0 || cnt_a !== 8'(errs0 + 3)) begin
            n_bad++;
            $display("FAIL loss_drop: got locked=%b cnt=%0d want 0 %0d", locked_a, cnt_a, errs0 + 3);
        end
        for (int i = 0; i < 5; i++) begin
            g = nxt(g);
            step(1, g);
            n_cmp++;
            if (act !== exp_vec() || locked_a !== (i == 4)) begin
                n_bad++;
                $display("FAIL relock[%0d]: got %h want %h", i, act, exp_vec());
            end
        end
    endtask

    task automatic test_zero();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(1, 0);
            n_cmp++;
            if (act !== exp_vec() || locked_a !== 1'b0) begin
                n_bad++;
                $display("FAIL zero_stream[%0d]: got %h want %h", i, act, exp_vec());
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        g = $urandom_range(1, 15);
        for (int i = 0; i < 5; i++) begin
            step(1, g);
            g = nxt(g);
        end
        for (int e = 0; e < 300; e++) begin
            step(1, g ^ $urandom_range(1, 15));
            g = nxt(g);
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++;
                $display("FAIL ovf_err[%0d]: got %h want %h", e, act, exp_vec());
            end
            for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin
                step(1, g);
                g = nxt(g);
            end
            if (e == 4) begin
                n_cmp++;
                if (cnt_b !== (SAT ? 2'd3 : 2'd1)) begin
                    n_bad++;
                    $display("FAIL ovf_e2_after5: got %0d want %0d", cnt_b, SAT ? 3 : 1);
                end
            end
        end
        n_cmp++;
        if (cnt_a !== (SAT ? 8'd255 : 8'd44) || locked_a !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_e8_after300: got cnt=%0d locked=%b want %0d 1",
                     cnt_a, locked_a, SAT ? 255 : 44);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        g = 5;
        for (int i = 0; i < 6; i++) begin
            step(1, g);
            g = nxt(g);
        end
        step(1, g ^ 1);
        #2;
        rst_n = 1'b0;
        m_clear();
        #1;
        n_cmp++;
        if (act !== 14'h0) begin
            n_bad++;
            $display("FAIL async_reset: got %h want 0000", act);
        end
        step(1, g);
        n_cmp++;
        if (act !== 14'h0) begin
            n_bad++;
            $display("FAIL reset_dominates: got %h want 0000", act);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        g = $urandom_range(1, 15);
        for (int i = 0; i < 3000; i++) begin
            int r, d;
            bit v;
            v = ($urandom_range(0, 9) < 8);
            r = $urandom_range(0, 99);
            if (v) begin
                g = nxt(g);
                if (r < 8) d = g ^ $urandom_range(1, 15);
                else if (r < 10) d = 0;
                else d = g;
            end else begin
                d = $urandom_range(0, 15);
            end
            step(v, d);
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got %h want %h", i, act, exp_vec());
            end
        end
    endtask

    initial begin
        m_clear();
        test_reset();
        test_lock();
        test_bubbles();
        test_single_error();
        test_loss();
        test_zero();
        test_overflow();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
